memory_stage: RTL

MEMORY_STAGE -- requirements
Module: memory_stage

---
 rtl/memory_stage.sv | 139 +++++++++++++
 1 files changed

// File: rtl/memory_stage.sv
// Memory stage of the in-order pipeline: issues one 64-bit data-bus access per
// load/store and hands the writeback record on through a valid/ready pair.
package pipes;
    typedef logic [63:0] word_t;
    typedef logic [4:0]  creg_addr_t;

    typedef struct packed {
        logic       b_jump;
        logic       memread;
        logic       memwrite;
        logic       regwrite;
        creg_addr_t dst;
    } ctl_t;

    typedef struct packed {
        word_t memdata;
        word_t result;
        ctl_t  ctl;
    } execute_data_t;

    typedef struct packed {
        logic       regwrite;
        creg_addr_t dst;
        word_t      regdata;
        word_t      memdata;
    } memory_data_t;
endpackage

module memory_stage
    import pipes::*;
(
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    input  execute_data_t in_data,
    output logic          in_ready,
    output logic          dreq_valid,
    output logic [63:0]   dreq_addr,
    output logic [2:0]    dreq_size,
    output logic [7:0]    dreq_strobe,
    output logic [63:0]   dreq_data,
    input  logic          dresp_data_ok,
    input  logic [63:0]   dresp_data,
    output logic          out_valid,
    output memory_data_t  out_data,
    input  logic          out_ready
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t     state;
    word_t      result_p1;
    word_t      memdata_p1;
    logic       memread_p1;
    logic       memwrite_p1;
    logic       regwrite_p1;
    creg_addr_t dst_p1;
    word_t      regdata_p1;

    logic in_xfer;
    logic out_xfer;
    logic in_mem;
    logic unused_bjump;

    // A store wins over a load when both flags are set.
    function automatic logic is_load(input logic rd, input logic wr);
        return rd & ~wr;
    endfunction

    always_comb begin
        in_ready = 1'b0;
        if (!reset) begin
            case (state)
                IDLE:    in_ready = 1'b1;
                DONE:    in_ready = out_ready;
                default: in_ready = 1'b0;
            endcase
        end
    end

    assign in_xfer      = in_valid & in_ready;
    assign out_xfer     = out_valid & out_ready;
    assign in_mem       = in_data.ctl.memread | in_data.ctl.memwrite;
    // Branch information has no consumer past execute.
    assign unused_bjump = in_data.ctl.b_jump;

    // Stage boundary: instruction latch, bus handshake and result register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            dreq_valid  <= 1'b0;
            out_valid   <= 1'b0;
            result_p1   <= '0;
            memdata_p1  <= '0;
            memread_p1  <= 1'b0;
            memwrite_p1 <= 1'b0;
            regwrite_p1 <= 1'b0;
            dst_p1      <= '0;
            regdata_p1  <= '0;
        end else if (in_xfer) begin
            result_p1   <= in_data.result;
            memdata_p1  <= in_data.memdata;
            memread_p1  <= in_data.ctl.memread;
            memwrite_p1 <= in_data.ctl.memwrite;
            regwrite_p1 <= in_data.ctl.regwrite;
            dst_p1      <= in_data.ctl.dst;
            if (in_mem) begin
                state      <= BUSY;
                dreq_valid <= 1'b1;
                out_valid  <= 1'b0;
            end else begin
                state      <= DONE;
                dreq_valid <= 1'b0;
                out_valid  <= 1'b1;
                regdata_p1 <= in_data.result;
            end
        end else if (state == BUSY && dresp_data_ok) begin
            state      <= DONE;
            dreq_valid <= 1'b0;
            out_valid  <= 1'b1;
            regdata_p1 <= is_load(memread_p1, memwrite_p1) ? dresp_data : result_p1;
        end else if (out_xfer) begin
            state     <= IDLE;
            out_valid <= 1'b0;
        end
    end

    // Request fields come straight from the latch, so they hold until the response.
    assign dreq_addr   = result_p1;
    assign dreq_data   = memdata_p1;
    assign dreq_size   = 3'b011;
    assign dreq_strobe = {8{memwrite_p1}};

    assign out_data.regwrite = regwrite_p1;
    assign out_data.dst      = dst_p1;
    assign out_data.regdata  = regdata_p1;
    assign out_data.memdata  = memdata_p1;

endmodule
